// File: rtl/axi_internal_ram.sv
// axi_internal_ram: AXI slave on-chip SRAM serving one burst at a time at 1 beat/cycle with pipelined reads
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   awaddr_i/awlen_i/awvalid_i write address (byte address, beats-1, valid)
//   awready_o                  write address accepted
//   wdata_i/wvalid_i/wlast_i   write data (wlast_i ignored, burst length comes from awlen_i)
//   wready_o                   write data accepted
//   bvalid_o/bready_i          write response
//   araddr_i/arlen_i/arvalid_i read address (byte address, beats-1, valid)
//   arready_o                  read address accepted
//   rdata_o/rvalid_o/rready_i  read data
//
// Optional feature: define AXI_RAM_BOUNDS_CHECK_EN to drop writes and return zero for reads
// whose full byte address is at or beyond MEM_SIZE*4; otherwise addresses wrap modulo MEM_SIZE.
module axi_internal_ram #(
  parameter int MEM_SIZE = 4096,
  localparam int ADDR_WIDTH = $clog2(MEM_SIZE)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] awaddr_i,
  input  logic [7:0]  awlen_i,
  input  logic        awvalid_i,
  output logic        awready_o,
  input  logic [31:0] wdata_i,
  input  logic        wvalid_i,
  input  logic        wlast_i,
  output logic        wready_o,
  output logic        bvalid_o,
  input  logic        bready_i,
  input  logic [31:0] araddr_i,
  input  logic [7:0]  arlen_i,
  input  logic        arvalid_i,
  output logic        arready_o,
  output logic [31:0] rdata_o,
  output logic        rvalid_o,
  input  logic        rready_i
);
`ifdef AXI_RAM_BOUNDS_CHECK_EN
  localparam int PW = 32;
`else
  localparam int PW = ADDR_WIDTH + 2;
`endif
  typedef enum logic [1:0] {IDLE, WRITE_BURST, WRITE_RESP, READ_BURST} state_t;
  state_t          state_q;
  logic [PW-1:0]   ptr_q, rptr_d;
  logic [7:0]      cnt_q;
  logic            grant_w_q;
  logic [31:0]     rdata_q;
  logic [31:0]     mem [MEM_SIZE];
  logic            pick_write, w_hs, r_hs, re, w_oob, r_oob;
  assign pick_write = awvalid_i && (!arvalid_i || !grant_w_q);
  assign awready_o  = state_q == IDLE && pick_write;
  assign arready_o  = state_q == IDLE && arvalid_i && !pick_write;
  assign wready_o   = state_q == WRITE_BURST;
  assign bvalid_o   = state_q == WRITE_RESP;
  assign rvalid_o   = state_q == READ_BURST;
  assign rdata_o    = rdata_q;
  assign w_hs       = wready_o && wvalid_i;
  assign r_hs       = rvalid_o && rready_i;
  // Read address runs one beat ahead only when the current beat is consumed, so rdata holds under backpressure
  assign rptr_d     = arready_o ? {araddr_i[PW-1:2], 2'b00} : r_hs ? ptr_q + PW'(4) : ptr_q;
  assign re         = arready_o || rvalid_o;
`ifdef AXI_RAM_BOUNDS_CHECK_EN
  localparam logic [31:0] LIMIT = 32'(MEM_SIZE) << 2;
  assign w_oob = ptr_q >= LIMIT;
  assign r_oob = rptr_d >= LIMIT;
  logic unused_ok;
  assign unused_ok = ^{awaddr_i[1:0], araddr_i[1:0], wlast_i};
`else
  assign w_oob = 1'b0;
  assign r_oob = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{awaddr_i[31:PW], araddr_i[31:PW], awaddr_i[1:0], araddr_i[1:0],
                       ptr_q[1:0], rptr_d[1:0], wlast_i};
`endif
  always_ff @(posedge clk)
    if (w_hs && !w_oob) mem[ptr_q[ADDR_WIDTH+1:2]] <= wdata_i;
  always_ff @(posedge clk or posedge reset)
    if (reset) rdata_q <= '0;
    else if (re) rdata_q <= r_oob ? '0 : mem[rptr_d[ADDR_WIDTH+1:2]];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      grant_w_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE:
          if (awready_o) begin
            ptr_q     <= {awaddr_i[PW-1:2], 2'b00};
            cnt_q     <= awlen_i;
            grant_w_q <= 1'b1;
            state_q   <= WRITE_BURST;
          end else if (arready_o) begin
            ptr_q     <= rptr_d;
            cnt_q     <= arlen_i;
            grant_w_q <= 1'b0;
            state_q   <= READ_BURST;
          end
        WRITE_BURST:
          if (w_hs) begin
            ptr_q <= ptr_q + PW'(4);
            cnt_q <= cnt_q - 8'd1;
            if (cnt_q == 8'd0) state_q <= WRITE_RESP;
          end
        WRITE_RESP:
          if (bready_i) state_q <= IDLE;
        READ_BURST:
          if (r_hs) begin
            ptr_q <= rptr_d;
            cnt_q <= cnt_q - 8'd1;
            if (cnt_q == 8'd0) state_q <= IDLE;
          end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_axi_internal_ram.sv
// tb_axi_internal_ram: directed self-checking bench for axi_internal_ram
module tb_axi_internal_ram;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
  logic [7:0]  awlen = '0, arlen = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [31:0] vec [16];
  int          checks = 0;
  int          errors = 0;
  axi_internal_ram #(.MEM_SIZE(1024)) dut (
    .clk(clk), .reset(reset),
    .awaddr_i(awaddr), .awlen_i(awlen), .awvalid_i(awvalid), .awready_o(awready),
    .wdata_i(wdata), .wvalid_i(wvalid), .wlast_i(wlast), .wready_o(wready),
    .bvalid_o(bvalid), .bready_i(bready),
    .araddr_i(araddr), .arlen_i(arlen), .arvalid_i(arvalid), .arready_o(arready),
    .rdata_o(rdata), .rvalid_o(rvalid), .rready_i(rready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_write(input logic [31:0] a, input logic [7:0] len, input bit both, input int bdelay);
    int n = 0;
    awaddr = a; awlen = len; awvalid = 1'b1;
    araddr = '0; arlen = '0; arvalid = both;
    #1;
    while (!awready && n < 20) begin tick; n++; end
    chk("awready", awready, 1);
    if (both) chk("arready_blocked", arready, 0);
    tick;
    awvalid = 1'b0; arvalid = 1'b0;
    chk("wready", wready, 1);
    wvalid = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = vec[i]; wlast = (i == int'(len));
      tick;
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("bvalid", bvalid, 1);
    if (bdelay > 0) begin
      araddr = a; arlen = '0; arvalid = 1'b1;
      #1;
      for (int k = 0; k < bdelay; k++) begin
        chk("bvalid_hold", bvalid, 1);
        chk("arready_in_resp", arready, 0);
        tick;
      end
    end
    bready = 1'b1;
    tick;
    bready = 1'b0;
    if (bdelay > 0) chk("arready_idle", arready, 1);
    arvalid = 1'b0;
    chk("bvalid_clr", bvalid, 0);
  endtask
  task automatic do_read(input logic [31:0] a, input logic [7:0] len, input bit both, input bit alt, input int abort_at);
    int n = 0;
    int i = 0;
    araddr = a; arlen = len; arvalid = 1'b1;
    awaddr = '0; awlen = '0; awvalid = both;
    #1;
    while (!arready && n < 20) begin tick; n++; end
    chk("arready", arready, 1);
    if (both) chk("awready_blocked", awready, 0);
    tick;
    arvalid = 1'b0; awvalid = 1'b0;
    chk("rvalid_first", rvalid, 1);
    n = 0;
    while (i <= int'(len) && n < 64) begin
      rready = alt ? (n % 2 == 0) : 1'b1;
      if (i == abort_at) begin
        reset = 1'b1;
        #1;
        chk("rvalid_reset", rvalid, 0);
        rready = 1'b0;
        return;
      end
      chk("rvalid_beat", rvalid, 1);
      chk($sformatf("rdata%0d", i), rdata, vec[i]);
      if (rready) i++;
      tick;
      n++;
    end
    rready = 1'b0;
    chk("beats", i, int'(len) + 1);
    chk("rvalid_end", rvalid, 0);
  endtask
  initial begin
    tick; tick;
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    reset = 1'b0;
    tick;
    vec[0] = 32'd1; vec[1] = 32'd2; vec[2] = 32'd3; vec[3] = 32'd4;
    do_write(32'h100, 8'd3, 1'b1, 0);
    do_read(32'h100, 8'd3, 1'b1, 1'b0, -1);
    for (int i = 0; i < 8; i++) vec[i] = 32'hC0DE_0000 + i;
    do_write(32'h200, 8'd7, 1'b0, 0);
    do_read(32'h200, 8'd7, 1'b0, 1'b1, -1);
    vec[0] = 32'h5A5A_A5A5;
    do_write(32'h300, 8'd0, 1'b0, 5);
    do_read(32'h300, 8'd0, 1'b0, 1'b0, -1);
    vec[0] = 32'h1234_5678;
    do_write(32'h0, 8'd0, 1'b0, 0);
    vec[0] = 32'hAAAA_0001; vec[1] = 32'hBBBB_0002;
    do_write(32'hFFC, 8'd1, 1'b0, 0);
`ifdef AXI_RAM_BOUNDS_CHECK_EN
    vec[1] = 32'h0;
    do_read(32'hFFC, 8'd1, 1'b0, 1'b0, -1);
    vec[0] = 32'h0;
    do_read(32'h1000, 8'd0, 1'b0, 1'b0, -1);
    vec[0] = 32'h1234_5678;
    do_read(32'h0, 8'd0, 1'b0, 1'b0, -1);
`else
    do_read(32'hFFC, 8'd1, 1'b0, 1'b0, -1);
    vec[0] = 32'hBBBB_0002;
    do_read(32'h1000, 8'd0, 1'b0, 1'b0, -1);
    do_read(32'h0, 8'd0, 1'b0, 1'b0, -1);
`endif
    vec[0] = 32'd1; vec[1] = 32'd2; vec[2] = 32'd3; vec[3] = 32'd4;
    do_read(32'h100, 8'd3, 1'b0, 1'b0, 2);
    tick;
    reset = 1'b0;
    tick;
    chk("post_rst_rvalid", rvalid, 0);
    do_read(32'h100, 8'd3, 1'b0, 1'b0, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
